// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: in-order L1->L2 dirty-line FIFO; define L2_WB_BYPASS_EN for miss forwarding
module l2_writeback_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         l1_write,
  input  logic [15:0]  l1_address,
  input  logic [127:0] l1_wdata,
  output logic         l1_resp,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_offset,
  input  logic         l2_resp,
  input  logic [15:0]  rd_address,
`ifdef L2_WB_BYPASS_EN
  output logic         fwd_hit,
  output logic [127:0] fwd_data,
`endif
  output logic         rd_block,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [11:0]   addr_mem [DEPTH];
  logic [127:0]  data_mem [DEPTH];
  logic          push, pop;
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign push     = l1_write && !full;
  assign pop      = l2_resp && !empty;
  assign l1_resp  = push;
  assign l2_write = !empty;
  // Head address is masked while empty so reset presents a clean zero despite unreset storage
  assign l2_address = empty ? '0 : {addr_mem[head], 4'h0};
  assign l2_offset  = !empty && addr_mem[head][0];
  assign l2_wdata   = data_mem[head];
  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Entry storage is written at the tail and deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= l1_address[15:4];
      data_mem[tail] <= l1_wdata;
    end
  end
`ifdef L2_WB_BYPASS_EN
  logic [AW-1:0] idx;
  logic          unused_low;
  assign unused_low = ^{l1_address[3:0], rd_address[3:0]};
  assign rd_block   = 1'b0;
  // Scan oldest to youngest so the last valid match (nearest the tail) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if ((AW+1)'(k) < count && addr_mem[idx] == rd_address[15:4]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end
`else
  logic unused_low;
  assign unused_low = ^{l1_address[3:0], rd_address};
  assign rd_block   = !empty;
`endif
endmodule
